// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path: controller state encoding,
// default frame length and the inter-byte timeout length in clk cycles.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVING = 2'd1,
        HOLD      = 2'd2
    } rx_state_e;

    localparam int FRAME_BYTES_DEFAULT = 16;

    // 1 second at 50 MHz; the timeout timer counts to this value.
    localparam int TIMEOUT_CYCLES = 50_000_000;

endpackage

// File: rtl/serial_receiver_frame_controller.sv
// Assembles UART bytes into fixed-length frames, holds each frame until the
// consumer takes it, and drops partial frames when the inter-byte timer expires.
module serial_receiver_frame_controller
    import serial_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [7:0]                         rx_data_i,
    input  logic                               rx_valid_i,
    input  logic                               timer_timed_out_i,
    output logic                               timer_reset_o,
    output logic [FRAME_BYTES*8-1:0]           frame_o,
    output logic                               frame_valid_o,
    input  logic                               frame_ready_i,
    output logic [$clog2(FRAME_BYTES+1)-1:0]   byte_count_o,
    output logic                               timeout_o,
    output logic                               overrun_o
);

    localparam int FW = FRAME_BYTES * 8;
    localparam int CW = $clog2(FRAME_BYTES + 1);

    rx_state_e       state_reg, state_next;
    logic [FW-1:0]   frame_reg, frame_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            timeout_reg, timeout_next;
    logic            overrun_reg, overrun_next;
    logic            byte_accepted;

    always_comb begin
        state_next    = state_reg;
        frame_next    = frame_reg;
        count_next    = count_reg;
        timeout_next  = 1'b0;
        overrun_next  = 1'b0;
        byte_accepted = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rx_valid_i) begin
                    byte_accepted = 1'b1;
                    frame_next    = {frame_reg[FW-9:0], rx_data_i};
                    count_next    = CW'(1);
                    state_next    = RECEIVING;
                end
            end

            RECEIVING: begin
                // A byte arriving alongside the timeout wins over the timeout.
                if (rx_valid_i) begin
                    byte_accepted = 1'b1;
                    frame_next    = {frame_reg[FW-9:0], rx_data_i};
                    count_next    = count_reg + CW'(1);
                    if (count_reg == CW'(FRAME_BYTES - 1)) begin
                        state_next = HOLD;
                    end
                end else if (timer_timed_out_i) begin
                    frame_next   = '0;
                    count_next   = '0;
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end
            end

            HOLD: begin
                if (frame_ready_i) begin
                    if (rx_valid_i) begin
                        byte_accepted = 1'b1;
                        frame_next    = {frame_reg[FW-9:0], rx_data_i};
                        count_next    = CW'(1);
                        state_next    = RECEIVING;
                    end else begin
                        count_next = '0;
                        state_next = IDLE;
                    end
                end else if (rx_valid_i) begin
                    overrun_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                frame_next = '0;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg   <= IDLE;
            frame_reg   <= '0;
            count_reg   <= '0;
            timeout_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            frame_reg   <= frame_next;
            count_reg   <= count_next;
            timeout_reg <= timeout_next;
            overrun_reg <= overrun_next;
        end
    end

    // The timer only runs inside a partial frame, measured from the last byte.
    assign timer_reset_o = reset_i || (state_reg != RECEIVING) || byte_accepted;
    assign frame_o       = frame_reg;
    assign frame_valid_o = (state_reg == HOLD);
    assign byte_count_o  = count_reg;
    assign timeout_o     = timeout_reg;
    assign overrun_o     = overrun_reg;

endmodule

// File: doc/serial_receiver_frame_controller.md
# serial_receiver_frame_controller

Sequences the serial receive path. Assembles single bytes from the UART receiver into fixed-length frames, restarts the 1-second inter-byte timeout timer on every accepted byte, and discards partial frames when that timer expires. It sits between the UART byte receiver and the hash-input loader inside the serial receiver. It drives the timeout timer's reset and consumes its timed-out flag; the timer is instantiated alongside this block, not inside it.

## Interface

Parameters:
- FRAME_BYTES, 16, number of bytes per frame (≥ 2)

Ports:
- clk_i, input, 1, system clock (50 MHz); single clock domain
- reset_i, input, 1, **synchronous, active-high reset**
- rx_data_i, input, 8, received byte
- rx_valid_i, input, 1, one-cycle strobe; rx_data_i valid
- timer_timed_out_i, input, 1, timed-out flag from the timeout timer
- timer_reset_o, output, 1, combinational restart request to the timeout timer
- frame_o, output, FRAME_BYTES*8, assembled frame; first received byte in the MSB byte
- frame_valid_o, output, 1, frame_o holds a complete frame
- frame_ready_i, input, 1, consumer accepts the frame
- byte_count_o, output, $clog2(FRAME_BYTES+1), bytes received in the current frame
- timeout_o, output, 1, one-cycle pulse: partial frame discarded
- overrun_o, output, 1, one-cycle pulse: byte dropped while a frame was held

## Operation

- States: IDLE, RECEIVING, HOLD.
- IDLE (count = 0):
  - rx_valid_i → shift byte in, count = 1, go to RECEIVING.
  - timer_timed_out_i is ignored.
- RECEIVING:
  - rx_valid_i → frame <= {frame[FRAME_BYTES*8-9:0], rx_data_i}, count+1.
  - When count reaches FRAME_BYTES → go to HOLD and set frame_valid_o.
- RECEIVING, no rx_valid_i and timer_timed_out_i = 1:
  - Clear count and frame_o to 0, pulse timeout_o, go to IDLE.
- Simultaneous rx_valid_i and timer_timed_out_i in RECEIVING: the byte wins. It is accepted and no timeout occurs.
- HOLD:
  - frame_valid_o = 1; frame_o and count are stable.
  - frame_ready_i = 1 → frame_valid_o clears next cycle and count clears. Go to IDLE, or go to RECEIVING with count = 1 if rx_valid_i is high in the same cycle; that byte becomes byte 0 of the next frame.
  - rx_valid_i without frame_ready_i → byte dropped, overrun_o pulses, frame_o is unchanged.
  - timer_timed_out_i is ignored.
- timer_reset_o = reset_i | (state ≠ RECEIVING) | accepted byte this cycle. The timer therefore runs only during an active partial frame, measured from the last accepted byte.
- Count arithmetic has no wrap: count never exceeds FRAME_BYTES.

## Timing

- Reset values: state IDLE; frame_o 0; frame_valid_o 0; byte_count_o 0; timeout_o 0; overrun_o 0; timer_reset_o 1 while reset_i is high.
- Reset mid-frame or mid-HOLD: everything returns to the reset values on the next edge and the partial or held frame is lost.
- Byte latency: a byte strobed at edge N appears in frame_o and byte_count_o after edge N+1.
- Frame completion: frame_valid_o rises in the cycle after the last byte's strobe.
- Consumer handshake: frame_valid_o falls the cycle after frame_ready_i is sampled high. frame_ready_i while frame_valid_o = 0 has no effect.
- Timeout pulse: timeout_o is high for exactly one cycle, the cycle after timer_timed_out_i is sampled high in RECEIVING.
- Timer interaction: the timer deasserts timed_out one cycle after timer_reset_o. The controller only samples timer_timed_out_i in RECEIVING, and that state is always entered with timer_reset_o asserted, so a stale flag is never seen.
- Back-to-back input: bytes on consecutive cycles are accepted at full rate.

## Structure

- Shared package serial_pkg:
  - state encoding: IDLE = 2'd0, RECEIVING = 2'd1, HOLD = 2'd2
  - FRAME_BYTES default constant
  - timeout cycle count constant (50,000,000), which the timer also uses
- Single module, no sub-modules: one next-state/datapath combinational block plus one registered block.
- The timeout timer is instantiated by the parent serial receiver and wired to timer_reset_o / timer_timed_out_i.
- Benches drive timer_timed_out_i directly rather than waiting 50M cycles.

## Test plan

- **Full frame:** FRAME_BYTES = 4, strobe 0xA1, 0xB2, 0xC3, 0xD4 on consecutive cycles → frame_o = 0xA1B2C3D4; frame_valid_o rises one cycle after the 4th strobe; byte_count_o = 4; timer_reset_o high on each strobe.
- **Timeout:** 2 bytes, then assert timer_timed_out_i → one-cycle timeout_o; byte_count_o = 0, frame_o = 0; the next byte starts a fresh frame with byte_count_o = 1.
- **Timeout collision:** rx_valid_i and timer_timed_out_i together at count 2 → byte accepted, count = 3, no timeout_o.
- **Overrun:** in HOLD, hold frame_ready_i low and strobe 0x55 → overrun_o pulses once; frame_o unchanged. Then assert frame_ready_i together with a 0x66 strobe → frame_valid_o falls, byte_count_o = 1, LSB byte = 0x66.
- **Reset mid-frame:** reset_i after 3 bytes → all outputs at reset values next cycle and timer_reset_o high during reset. A new 4-byte frame then assembles correctly.
- **Idle timer:** timer_timed_out_i held high in IDLE and HOLD → no timeout_o and no state change.
